// File: rtl/vid_pkg.sv
// vid_pkg: shared register layouts, pixel word fields and FIFO command codes
package vid_pkg;
    localparam int VID_CW = 13;
    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;
    typedef struct packed {
        logic [24:0] rsvd;
        logic [5:0]  pcnt;
        logic        en;
    } cr_t;
    typedef struct packed {
        logic [VID_CW-1:0] hend;
        logic [VID_CW-1:0] hsize;
    } h1_t;
    typedef struct packed {
        logic [VID_CW-1:0] hsync_end;
        logic [VID_CW-1:0] hsync_start;
    } h2_t;
    typedef struct packed {
        logic [VID_CW-1:0] vend;
        logic [VID_CW-1:0] vsize;
    } v1_t;
    typedef struct packed {
        logic [VID_CW-1:0] vsync_end;
        logic [VID_CW-1:0] vsync_start;
    } v2_t;
    typedef enum logic [1:0] {
        CMD_IDLE     = 2'b00,
        CMD_PUSH     = 2'b01,
        CMD_POP      = 2'b10,
        CMD_PUSH_POP = 2'b11
    } fifo_cmd_e;
endpackage

// File: rtl/vid_pix_fifo.sv
// vid_pix_fifo: synchronous pixel FIFO with flush, level and full/empty flags
module vid_pix_fifo
    import vid_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    fifo_cmd_e cmd;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign do_push = push && !full && !flush;
    assign do_pop = pop && !empty && !flush;
    assign cmd = fifo_cmd_e'({do_pop, do_push});
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            level <= cmd == CMD_PUSH ? level + 1'b1 : cmd == CMD_POP ? level - 1'b1 : level;
        end
    end
endmodule

// File: rtl/vid_raster_out.sv
// vid_raster_out: raster timing generator popping buffered pixels onto RGB
module vid_raster_out
    import vid_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CW = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [5:0]                    pcnt,
    input  logic [CW-1:0]                 hend,
    input  logic [CW-1:0]                 hsize,
    input  logic [CW-1:0]                 hsync_start,
    input  logic [CW-1:0]                 hsync_end,
    input  logic [CW-1:0]                 vend,
    input  logic [CW-1:0]                 vsize,
    input  logic [CW-1:0]                 vsync_start,
    input  logic [CW-1:0]                 vsync_end,
    input  logic                          wr_valid,
    input  logic [31:0]                   wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start,
    output logic                          underrun,
    output logic                          hsync,
    output logic                          hblank,
    output logic                          vsync,
    output logic                          vblank,
    output logic [7:0]                    R,
    output logic [7:0]                    G,
    output logic [7:0]                    B
);
    typedef enum logic {DISABLED, RUN} state_e;
    state_e state;
    logic [5:0] pcnt_s, div;
    logic [CW-1:0] hend_s, hsize_s, hss_s, hse_s, vend_s, vsize_s, vss_s, vse_s;
    logic [CW-1:0] hcnt, vcnt, hlast, vlast;
    logic [23:0] rd_data;
    logic full, empty, tick, active, pop, unused_pad;
    assign unused_pad = ^wr_data[31:24];
    assign hlast = hend_s == '0 ? '0 : hend_s - 1'b1;
    assign vlast = vend_s == '0 ? '0 : vend_s - 1'b1;
    assign tick = state == RUN && en && div == pcnt_s;
    assign active = hcnt < hsize_s && vcnt < vsize_s;
    assign pop = tick && active && !empty;
    assign wr_ready = !full;
    vid_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(24)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(!en),
        .push(wr_valid),
        .pop(pop),
        .din(wr_data[23:0]),
        .dout(rd_data),
        .level(fifo_level),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= DISABLED;
            div <= '0;
            hcnt <= '0;
            vcnt <= '0;
            {pcnt_s, hend_s, hsize_s, hss_s, hse_s, vend_s, vsize_s, vss_s, vse_s} <= '0;
            {frame_start, underrun, hsync, hblank, vsync, vblank} <= '0;
            {R, G, B} <= '0;
        end else if (state == DISABLED) begin
            state <= RUN;
            frame_start <= 1'b1;
            {pcnt_s, hend_s, hsize_s, hss_s, hse_s, vend_s, vsize_s, vss_s, vse_s} <=
                {pcnt, hend, hsize, hsync_start, hsync_end, vend, vsize, vsync_start, vsync_end};
        end else begin
            frame_start <= 1'b0;
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hblank <= hcnt >= hsize_s;
                hsync <= hcnt >= hss_s && hcnt < hse_s;
                vblank <= vcnt >= vsize_s;
                vsync <= vcnt >= vss_s && vcnt < vse_s;
                R <= pop ? rd_data[PIX_R_LSB +: 8] : '0;
                G <= pop ? rd_data[PIX_G_LSB +: 8] : '0;
                B <= pop ? rd_data[PIX_B_LSB +: 8] : '0;
                underrun <= underrun || (active && empty);
                hcnt <= hcnt == hlast ? '0 : hcnt + 1'b1;
                if (hcnt == hlast) begin
                    vcnt <= vcnt == vlast ? '0 : vcnt + 1'b1;
                    if (vcnt == vlast) begin
                        frame_start <= 1'b1;
                        {pcnt_s, hend_s, hsize_s, hss_s, hse_s, vend_s, vsize_s, vss_s, vse_s} <=
                            {pcnt, hend, hsize, hsync_start, hsync_end, vend, vsize, vsync_start, vsync_end};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vid_raster_out.sv
// tb_vid_raster_out: reference-model and scoreboard check of the raster output stage
module tb_vid_raster_out;
    localparam int DEPTH = 16;
    localparam int CW = 13;
    localparam int LW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset, en, wr_valid;
    logic [5:0] pcnt;
    logic [CW-1:0] hend, hsize, hsync_start, hsync_end, vend, vsize, vsync_start, vsync_end;
    logic [31:0] wr_data;
    logic wr_ready, frame_start, underrun, hsync, hblank, vsync, vblank;
    logic [LW-1:0] fifo_level;
    logic [7:0] R, G, B;

    always #5 clk = ~clk;

    vid_raster_out #(.FIFO_DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
        .hend(hend), .hsize(hsize), .hsync_start(hsync_start), .hsync_end(hsync_end),
        .vend(vend), .vsize(vsize), .vsync_start(vsync_start), .vsync_end(vsync_end),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .fifo_level(fifo_level),
        .frame_start(frame_start), .underrun(underrun),
        .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
        .R(R), .G(G), .B(B)
    );

    typedef struct {
        int pcnt, hend, hsize, hss, hse, vend, vsize, vss, vse;
        int per, hs, vs, act;
    } row_t;
    row_t rows[6];

    int nvec = 0, nerr = 0, feed = 0;
    logic [23:0] q[$];
    bit mrun;
    int mph, mj, sp, sh, shsize, shss, shse, sv, svsize, svss, svse;
    bit e_hs, e_hb, e_vs, e_vb, e_fs, e_ur;
    logic [23:0] e_rgb;

    task automatic chk(input string n, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic load();
        sp = int'(pcnt);
        sh = hend == 0 ? 1 : int'(hend);
        sv = vend == 0 ? 1 : int'(vend);
        shsize = int'(hsize); shss = int'(hsync_start); shse = int'(hsync_end);
        svsize = int'(vsize); svss = int'(vsync_start); svse = int'(vsync_end);
    endtask

    task automatic model_edge();
        bit acc;
        int h, v;
        acc = wr_valid && en && !reset && q.size() < DEPTH;
        if (reset || !en) begin
            q.delete();
            mrun = 0;
            {e_hs, e_hb, e_vs, e_vb, e_fs, e_ur} = '0;
            e_rgb = '0;
        end else if (!mrun) begin
            mrun = 1; load(); mph = 0; mj = 0; e_fs = 1;
        end else begin
            e_fs = 0;
            if (mph == sp) begin
                h = mj % sh;
                v = mj / sh;
                e_hb = h >= shsize; e_hs = h >= shss && h < shse;
                e_vb = v >= svsize; e_vs = v >= svss && v < svse;
                e_rgb = '0;
                if (!e_hb && !e_vb) begin
                    if (q.size() > 0) e_rgb = q.pop_front();
                    else e_ur = 1;
                end
                mj++;
                if (mj == sh * sv) begin
                    mj = 0; load(); e_fs = 1;
                end
                mph = 0;
            end else mph++;
        end
        if (acc) q.push_back(wr_data[23:0]);
    endtask

    task automatic step();
        if (feed != 0) begin
            wr_valid = 1'b1;
            wr_data = {8'h00, 24'($urandom)};
            if (feed > 0) feed--;
        end else wr_valid = 1'b0;
        model_edge();
        @(posedge clk); #1;
        chk("hsync", hsync, e_hs);
        chk("hblank", hblank, e_hb);
        chk("vsync", vsync, e_vs);
        chk("vblank", vblank, e_vb);
        chk("rgb", {R, G, B}, e_rgb);
        chk("frame_start", frame_start, e_fs);
        chk("underrun", underrun, e_ur);
        chk("fifo_level", fifo_level, q.size());
        chk("wr_ready", wr_ready, q.size() < DEPTH);
    endtask

    task automatic cfg(input row_t r);
        pcnt = 6'(r.pcnt); hend = CW'(r.hend); hsize = CW'(r.hsize);
        hsync_start = CW'(r.hss); hsync_end = CW'(r.hse);
        vend = CW'(r.vend); vsize = CW'(r.vsize);
        vsync_start = CW'(r.vss); vsync_end = CW'(r.vse);
    endtask

    task automatic run_frame(input int chg_at, output int per, output int hs, output int vs, output int act);
        int n;
        per = 0; hs = 0; vs = 0; act = 0; n = 0;
        while (!frame_start && n < 2000) begin step(); n++; end
        do begin
            if (per == chg_at) hsize = CW'(6);
            per++;
            hs += int'(hsync); vs += int'(vsync); act += int'(!hblank && !vblank);
            step();
        end while (!frame_start && per < 2000);
    endtask

    task automatic restart(input row_t r, input int f);
        reset = 1'b1; en = 1'b0; feed = 0;
        step();
        reset = 1'b0;
        cfg(r);
        en = 1'b1; feed = f;
    endtask

    initial begin
        int per, hs, vs, act, n;
        rows[0] = '{0, 8, 4, 5, 7, 4, 2, 2, 4, 32, 8, 16, 8};
        rows[1] = '{2, 8, 4, 5, 7, 4, 2, 2, 4, 96, 24, 48, 24};
        rows[2] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 2, 2, 2, 2};
        rows[3] = '{0, 6, 2, 4, 3, 3, 3, 1, 1, 18, 0, 0, 6};
        rows[4] = '{0, 5, 20, 0, 5, 3, 3, 0, 2, 15, 15, 10, 15};
        rows[5] = '{3, 4, 0, 1, 2, 2, 2, 0, 1, 32, 8, 16, 0};
        reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cfg(rows[0]);
        step();
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_level", fifo_level, 0);
        chk("reset_rgb", {R, G, B}, 0);

        for (int i = 0; i < 6; i++) begin
            restart(rows[i], -1);
            run_frame(-1, per, hs, vs, act);
            run_frame(-1, per, hs, vs, act);
            chk($sformatf("row%0d_period", i), per, rows[i].per);
            chk($sformatf("row%0d_hsync", i), hs, rows[i].hs);
            chk($sformatf("row%0d_vsync", i), vs, rows[i].vs);
            chk($sformatf("row%0d_active", i), act, rows[i].act);
        end

        restart(rows[0], 3);
        for (int i = 0; i < 4; i++) step();
        chk("ur_before", underrun, 0);
        step();
        chk("ur_set", underrun, 1);
        chk("ur_rgb", {R, G, B}, 0);
        chk("ur_hblank", hblank, 0);
        for (int i = 0; i < 40; i++) step();
        chk("ur_sticky", underrun, 1);
        chk("ur_level", fifo_level, 0);
        en = 1'b0;
        step();
        chk("ur_cleared", underrun, 0);

        restart(rows[5], 20);
        hsize = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("full_level", fifo_level, i < DEPTH ? i : DEPTH);
            chk("full_ready", wr_ready, i < DEPTH);
        end

        restart(rows[0], -1);
        n = 0;
        while (!(mrun && mj == 11 && mph == 0) && n < 200) begin step(); n++; end
        reset = 1'b1;
        step();
        chk("rst_flags", {hsync, hblank, vsync, vblank, frame_start, underrun}, 0);
        chk("rst_rgb", {R, G, B}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", wr_ready, 1);
        reset = 1'b0;
        step();
        chk("rst_restart_fs", frame_start, 1);
        run_frame(-1, per, hs, vs, act);
        chk("rst_period", per, 32);

        restart(rows[0], -1);
        run_frame(-1, per, hs, vs, act);
        run_frame(10, per, hs, vs, act);
        chk("shadow_cur_active", act, 8);
        run_frame(-1, per, hs, vs, act);
        chk("shadow_next_active", act, 12);
        chk("shadow_next_period", per, 32);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end
endmodule
